// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with start/busy/done handshake
// Operands are widened by one bit so one datapath serves signed and unsigned modes.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       a_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    // Booth recoding of the current pair {Q[0], Q_1}
    case ({q_q[0], q1_q})
      2'b10:   a_sum = a_q - m_q;
      2'b01:   a_sum = a_q + m_q;
      default: a_sum = a_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {is_signed & multiplicand[WIDTH-1], multiplicand};
          q_d     = {is_signed & multiplier[WIDTH-1], multiplier};
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH + 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Arithmetic right shift of {A, Q, Q_1}
        a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_d   = {a_sum[0], q_q[WIDTH:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          product_d = {a_d[WIDTH-2:0], q_d};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
